audio_arbiter: RTL and testbench

//  Shares the single audio_codec write port between N_SRC sound players (gunshot, kill, gameover, ...).

---
 rtl/audio_arbiter.sv | 163 ++++++++++++++++
 tb/tb_audio_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_arbiter.sv
// audio_arbiter
// Shares the single audio codec write port between N_SRC sound players.
// A fixed-priority pick (highest index wins) selects one owner per sound.
// Samples are pulled from the owner over valid/ready and forwarded to the
// codec one at a time as write_ready allows. The owner keeps the port until
// it flags its last sample or the FETCH watchdog gives up on it.
//
// Build option: define AUDIO_ARB_PREEMPT_EN to let a higher-index request
// take the port over at the next sample boundary (FETCH only). Without it the
// owner always runs to its last sample or to the watchdog.
module audio_arbiter #(
   parameter int N_SRC   = 4,
   parameter int DW      = 24,
   parameter int TIMEOUT = 4096
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_SRC-1:0]         src_req,
   input  logic [N_SRC-1:0]         src_valid,
   input  logic [N_SRC-1:0]         src_last,
   input  logic [N_SRC*DW-1:0]      src_data,
   output logic [N_SRC-1:0]         src_ready,
   input  logic                     aud_write_ready,
   output logic                     aud_write,
   output logic [DW-1:0]            aud_write_d,
   output logic [$clog2(N_SRC)-1:0] owner,
   output logic                     busy,
   output logic                     timeout_err
);

   localparam int OW  = $clog2(N_SRC);
   localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit WDOG_EN = (TIMEOUT > 0);
   localparam logic [WDW-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

`ifdef AUDIO_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WRITE
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic            busy_q, busy_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            last_q, last_d;
   logic            write_q, write_d;
   logic            tmo_q, tmo_d;
   logic [WDW-1:0]  wdog_q, wdog_d;

   logic [OW-1:0]   hi_idx;
   logic            any_req;
   logic [DW-1:0]   owner_data;

   assign any_req    = |src_req;
   assign owner_data = src_data[owner_q*DW +: DW];

   // Priority encoder: highest requesting index wins.
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (src_req[i]) hi_idx = OW'(i);
      end
   end

   // Next-state logic for the IDLE -> FETCH -> WRITE ownership cycle.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      owner_d = owner_q;
      busy_d  = busy_q;
      wdata_d = wdata_q;
      last_d  = last_q;
      write_d = 1'b0;
      tmo_d   = 1'b0;
      wdog_d  = wdog_q;

      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d = hi_idx;
               busy_d  = 1'b1;
               wdog_d  = '0;
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (PREEMPT && any_req && (hi_idx > owner_q)) begin
               // Ownership moves at the sample boundary; whatever the old
               // owner offered this cycle is not written.
               owner_d = hi_idx;
               wdog_d  = '0;
            end else if (src_valid[owner_q]) begin
               wdata_d = owner_data;
               last_d  = src_last[owner_q];
               wdog_d  = '0;
               state_d = ST_WRITE;
            end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
               tmo_d   = 1'b1;
               busy_d  = 1'b0;
               wdog_d  = '0;
               state_d = ST_IDLE;
            end else if (wdog_q != '1) begin
               wdog_d  = wdog_q + 1'b1;
            end
         end

         ST_WRITE: begin
            if (aud_write_ready) begin
               write_d = 1'b1;
               wdog_d  = '0;
               if (last_q) begin
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: flops take non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         busy_q  <= 1'b0;
         wdata_q <= '0;
         last_q  <= 1'b0;
         write_q <= 1'b0;
         tmo_q   <= 1'b0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         busy_q  <= busy_d;
         wdata_q <= wdata_d;
         last_q  <= last_d;
         write_q <= write_d;
         tmo_q   <= tmo_d;
         wdog_q  <= wdog_d;
      end
   end

   assign src_ready   = (state_q == ST_FETCH) ? (N_SRC'(1) << owner_q) : '0;
   assign aud_write   = write_q;
   assign aud_write_d = wdata_q;
   assign owner       = owner_q;
   assign busy        = busy_q;
   assign timeout_err = tmo_q;

endmodule

// File: tb/tb_audio_arbiter.sv
// tb_audio_arbiter
// Table of arbitration vectors from IDLE plus hand-written sequences for
// multi-sample sounds, priority ordering, codec back-pressure, the watchdog
// and (build-dependent) preemption. Written samples are checked against a
// queue of expected data filled when each sound is set up.
module tb_audio_arbiter;

   localparam int N   = 4;
   localparam int DW  = 24;
   localparam int TMO = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      src_req;
   logic [N-1:0]      src_valid;
   logic [N-1:0]      src_last;
   logic [N*DW-1:0]   src_data;
   logic [N-1:0]      src_ready;
   logic              aud_write_ready;
   logic              aud_write;
   logic [DW-1:0]     aud_write_d;
   logic [1:0]        owner;
   logic              busy;
   logic              timeout_err;

   int total = 0;
   int bad   = 0;

   // Per-player sample scripts: bit DW is the last flag.
   logic [DW:0]   smp [N][8];
   int            cnt [N];
   int            pos [N];
   logic          took [N];
   logic [DW-1:0] exp_q [$];

   typedef struct {
      logic [3:0] req;
      logic [1:0] own;
      logic       bsy;
      logic [3:0] rdy;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   audio_arbiter #(
      .N_SRC   (N),
      .DW      (DW),
      .TIMEOUT (TMO)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .src_req         (src_req),
      .src_valid       (src_valid),
      .src_last        (src_last),
      .src_data        (src_data),
      .src_ready       (src_ready),
      .aud_write_ready (aud_write_ready),
      .aud_write       (aud_write),
      .aud_write_d     (aud_write_d),
      .owner           (owner),
      .busy            (busy),
      .timeout_err     (timeout_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_src(input int i, input int n, input logic [DW-1:0] base);
      for (int k = 0; k < n; k++) smp[i][k] = {(k == n - 1), base + DW'(k)};
      cnt[i] = n;
   endtask

   task automatic expect_src(input int i, input int from, input int to);
      for (int k = from; k < to; k++) exp_q.push_back(smp[i][k][DW-1:0]);
   endtask

   task automatic do_reset();
      reset_n         = 1'b0;
      src_req         = '0;
      aud_write_ready = 1'b0;
      for (int i = 0; i < N; i++) cnt[i] = 0;
      exp_q.delete();
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_writes(input string name, input int n, input int budget);
      int got;
      got = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         tick();
         if (aud_write === 1'b1) got++;
      end
      check(name, got, n);
   endtask

   // Player models and write monitor, both on the falling edge.
   task automatic bfm();
      logic          prev_rdy;
      logic          prev_wr;
      logic [DW-1:0] exp_d;
      prev_rdy = 1'b0;
      prev_wr  = 1'b0;
      forever begin
         @(negedge clk);
         if (aud_write === 1'b1) begin
            check("write_after_ready", prev_rdy, 1);
            check("write_spacing", prev_wr, 0);
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_d = exp_q.pop_front();
               check("write_data", aud_write_d, exp_d);
            end
         end
         prev_rdy = aud_write_ready;
         prev_wr  = aud_write;
         for (int i = 0; i < N; i++) begin
            if (reset_n !== 1'b1) begin
               pos[i]  = 0;
               took[i] = 1'b0;
            end else if (took[i]) begin
               pos[i]++;
            end
            src_valid[i]          = (pos[i] < cnt[i]);
            src_data[i*DW +: DW]  = smp[i][(pos[i] < 8) ? pos[i] : 7][DW-1:0];
            src_last[i]           = smp[i][(pos[i] < 8) ? pos[i] : 7][DW];
            took[i]               = src_valid[i] & src_ready[i];
         end
      end
   endtask

   initial begin
      int stall_bad;

      vecs[0] = '{req: 4'b0000, own: 2'd0, bsy: 1'b0, rdy: 4'b0000};
      vecs[1] = '{req: 4'b0001, own: 2'd0, bsy: 1'b1, rdy: 4'b0001};
      vecs[2] = '{req: 4'b0010, own: 2'd1, bsy: 1'b1, rdy: 4'b0010};
      vecs[3] = '{req: 4'b0011, own: 2'd1, bsy: 1'b1, rdy: 4'b0010};
      vecs[4] = '{req: 4'b0110, own: 2'd2, bsy: 1'b1, rdy: 4'b0100};
      vecs[5] = '{req: 4'b1010, own: 2'd3, bsy: 1'b1, rdy: 4'b1000};
      vecs[6] = '{req: 4'b1111, own: 2'd3, bsy: 1'b1, rdy: 4'b1000};
      vecs[7] = '{req: 4'b1000, own: 2'd3, bsy: 1'b1, rdy: 4'b1000};

      reset_n         = 1'b0;
      src_req         = '0;
      aud_write_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         cnt[i]  = 0;
         pos[i]  = 0;
         took[i] = 1'b0;
      end
      fork
         bfm();
      join_none

      // Reset held with every player requesting and valid.
      for (int i = 0; i < N; i++) load_src(i, 1, DW'(24'h0A0000 + i));
      src_req         = 4'hF;
      aud_write_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("reset_outputs",
               {src_ready, aud_write, owner, busy, timeout_err, aud_write_d}, 64'd0);
      end

      // Arbitration from IDLE.
      for (int v = 0; v < 8; v++) begin
         do_reset();
         src_req = vecs[v].req;
         tick();
         check("arb_owner", owner, vecs[v].own);
         check("arb_busy", busy, vecs[v].bsy);
         check("arb_ready", src_ready, vecs[v].rdy);
      end

      // Single player, three samples, codec always ready.
      do_reset();
      load_src(0, 3, 24'h000001);
      expect_src(0, 0, 3);
      aud_write_ready = 1'b1;
      src_req         = 4'b0001;
      tick();
      check("p0_owner", owner, 0);
      check("p0_busy", busy, 1);
      wait_writes("p0_writes", 3, 60);
      check("p0_busy_after_last", busy, 0);
      check("p0_owner_held", owner, 0);
      src_req = '0;
      tick();
      check("p0_queue_drained", exp_q.size(), 0);

      // Two simultaneous requests: player 3 first, then player 1.
      do_reset();
      load_src(3, 2, 24'h300001);
      load_src(1, 2, 24'h100001);
      expect_src(3, 0, 2);
      expect_src(1, 0, 2);
      aud_write_ready = 1'b1;
      src_req         = 4'b1010;
      tick();
      check("pri_owner_hi", owner, 3);
      check("pri_ready_hi", src_ready, 4'b1000);
      src_req = 4'b0010;
      wait_writes("pri_writes_hi", 2, 40);
      check("pri_busy_gap", busy, 0);
      tick();
      check("pri_owner_lo", owner, 1);
      check("pri_busy_lo", busy, 1);
      wait_writes("pri_writes_lo", 2, 40);
      src_req = '0;
      tick();
      check("pri_queue_drained", exp_q.size(), 0);

      // Codec back-pressure for 100 cycles while a sample waits in WRITE.
      do_reset();
      load_src(2, 2, 24'hA5A5A5);
      expect_src(2, 0, 2);
      src_req = 4'b0100;
      tick();
      tick();
      check("stall_data_latched", aud_write_d, 24'hA5A5A5);
      stall_bad = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (aud_write !== 1'b0 || aud_write_d !== 24'hA5A5A5) stall_bad++;
      end
      check("stall_quiet", stall_bad, 0);
      aud_write_ready = 1'b1;
      tick();
      check("stall_release_write", aud_write, 1);
      check("stall_release_data", aud_write_d, 24'hA5A5A5);
      tick();
      check("stall_single_pulse", aud_write, 0);
      wait_writes("stall_tail_write", 1, 20);
      src_req = '0;
      tick();
      check("stall_queue_drained", exp_q.size(), 0);

      // Watchdog: owner never presents a sample.
      do_reset();
      aud_write_ready = 1'b1;
      src_req         = 4'b0010;
      tick();
      check("wdog_busy_start", busy, 1);
      stall_bad = 0;
      for (int k = 2; k <= TMO; k++) begin
         tick();
         if (timeout_err !== 1'b0 || busy !== 1'b1) stall_bad++;
      end
      check("wdog_no_early_fire", stall_bad, 0);
      src_req = '0;
      tick();
      check("wdog_pulse", timeout_err, 1);
      check("wdog_busy_drop", busy, 0);
      check("wdog_ready_drop", src_ready, 0);
      tick();
      check("wdog_pulse_end", timeout_err, 0);
      check("wdog_idle", busy, 0);

      // Higher request arriving mid-sound.
      do_reset();
      load_src(0, 4, 24'h000011);
      load_src(2, 1, 24'h000021);
`ifdef AUDIO_ARB_PREEMPT_EN
      exp_q.push_back(24'h000011);
      exp_q.push_back(24'h000021);
      exp_q.push_back(24'h000013);
      exp_q.push_back(24'h000014);
`else
      expect_src(0, 0, 4);
      expect_src(2, 0, 1);
`endif
      aud_write_ready = 1'b1;
      src_req         = 4'b0001;
      wait_writes("mid_first_write", 1, 20);
      src_req = 4'b0101;
      tick();
`ifdef AUDIO_ARB_PREEMPT_EN
      check("mid_owner_switch", owner, 2);
      check("mid_ready_moved", src_ready, 4'b0100);
      src_req = 4'b0001;
      wait_writes("mid_rest_writes", 3, 60);
`else
      check("mid_owner_kept", owner, 0);
      wait_writes("mid_p0_writes", 3, 60);
      tick();
      check("mid_owner_next", owner, 2);
      wait_writes("mid_p2_write", 1, 20);
`endif
      src_req = '0;
      tick();
      check("mid_queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
